// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: drives the data port, aligns and extends load data,
// lane-shifts store data and stalls the upstream pipeline while a bus access is outstanding.
module lsu_mem_stage #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic                  mem_stall_o,
  output logic                  load_valid_o,
  output logic [XLEN-1:0]       load_data_o,
  output logic                  access_fault_o,
  output logic                  data_r_en_o,
  output logic [ADDR_WIDTH-1:0] data_r_addr_o,
  input  logic                  i_data_r_valid,
  input  logic [XLEN-1:0]       i_data_r,
  output logic                  data_w_en_o,
  output logic [ADDR_WIDTH-1:0] data_w_addr_o,
  output logic [XLEN-1:0]       data_w_o,
  output logic [7:0]            data_w_mask_o,
  input  logic                  i_data_w_ready
);

  localparam int unsigned OFF_W  = 3;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t                state;
  logic [2:0]            f3_q;
  logic [OFF_W-1:0]      off_q;

  logic [OFF_W-1:0]      off;
  logic                  req;
  logic                  legal;
  logic                  aligned;
  logic                  start;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [MASK_W-1:0]     size_mask;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       ext;

  assign off          = addr_i[OFF_W-1:0];
  assign addr_aligned = {addr_i[ADDR_WIDTH-1:OFF_W], 3'b000};
  assign req          = req_valid_i & (mem_read_i | mem_write_i);

  // Request decode; a simultaneous read and write is treated as a load.
  always_comb begin
    legal     = mem_read_i ? (funct3_i != 3'b111) : ~funct3_i[2];
    aligned   = 1'b1;
    size_mask = 8'h01;
    case (funct3_i[1:0])
      2'b00: begin aligned = 1'b1;                size_mask = 8'h01; end
      2'b01: begin aligned = ~off[0];             size_mask = 8'h03; end
      2'b10: begin aligned = (off[1:0] == 2'b00); size_mask = 8'h0F; end
      default: begin aligned = (off == 3'b000);   size_mask = 8'hFF; end
    endcase
  end

  assign start = (state == IDLE) & req & legal & aligned;
  assign fault = (state == IDLE) & req & ~(legal & aligned);

  assign mem_stall_o = ~rst & (start | (state == RD_WAIT) | (state == WR_WAIT));

  // Load alignment and extension using the size/sign latched at request time.
  always_comb begin
    shifted = i_data_r >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      f3_q           <= '0;
      off_q          <= '0;
      load_valid_o   <= 1'b0;
      load_data_o    <= '0;
      access_fault_o <= 1'b0;
      data_r_en_o    <= 1'b0;
      data_r_addr_o  <= '0;
      data_w_en_o    <= 1'b0;
      data_w_addr_o  <= '0;
      data_w_o       <= '0;
      data_w_mask_o  <= '0;
    end else begin
      load_valid_o   <= 1'b0;
      access_fault_o <= fault;
      case (state)
        IDLE: begin
          if (start) begin
            if (mem_read_i) begin
              data_r_en_o   <= 1'b1;
              data_r_addr_o <= addr_aligned;
              f3_q          <= funct3_i;
              off_q         <= off;
              state         <= RD_WAIT;
            end else begin
              data_w_en_o   <= 1'b1;
              data_w_addr_o <= addr_aligned;
              data_w_o      <= wdata_i << {off, 3'b000};
              data_w_mask_o <= size_mask << off;
              state         <= WR_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (i_data_r_valid) begin
            load_data_o  <= ext;
            data_r_en_o  <= 1'b0;
            load_valid_o <= 1'b1;
            state        <= RESP;
          end
        end
        WR_WAIT: begin
          if (i_data_w_ready) begin
            data_w_en_o <= 1'b0;
            state       <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed loads, stores, faults, reset and back-to-back traffic.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        mem_stall, load_valid, access_fault;
  logic [63:0] load_data;
  logic        r_en, rvalid, w_en, wready;
  logic [63:0] r_addr, rdata, w_addr, w_data;
  logic [7:0]  w_mask;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .mem_stall_o(mem_stall), .load_valid_o(load_valid), .load_data_o(load_data),
    .access_fault_o(access_fault),
    .data_r_en_o(r_en), .data_r_addr_o(r_addr),
    .i_data_r_valid(rvalid), .i_data_r(rdata),
    .data_w_en_o(w_en), .data_w_addr_o(w_addr), .data_w_o(w_data),
    .data_w_mask_o(w_mask), .i_data_w_ready(wready)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] lq[$];
  logic [63:0] rq[$];
  logic [63:0] wq_addr[$];
  logic [63:0] wq_data[$];
  logic [7:0]  wq_mask[$];
  int          fq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT presents one.
  logic prev_r = 1'b0;
  logic prev_w = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_r = 1'b0;
      prev_w = 1'b0;
    end else begin
      if (load_valid) begin
        if (lq.size() == 0) check("unexpected_load_valid", 64'(load_valid), 64'd0);
        else check("load_data", load_data, lq.pop_front());
      end
      if (access_fault) begin
        if (fq.size() == 0) check("unexpected_fault", 64'(access_fault), 64'd0);
        else void'(fq.pop_front());
      end
      if (r_en && !prev_r) begin
        if (rq.size() == 0) check("unexpected_read", 64'(r_en), 64'd0);
        else check("read_addr", r_addr, rq.pop_front());
      end
      if (w_en && !prev_w) begin
        if (wq_addr.size() == 0) check("unexpected_write", 64'(w_en), 64'd0);
        else begin
          check("write_addr", w_addr, wq_addr.pop_front());
          check("write_data", w_data, wq_data.pop_front());
          check("write_mask", 64'(w_mask), 64'(wq_mask.pop_front()));
        end
      end
      prev_r = r_en;
      prev_w = w_en;
    end
  end

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rd, input int dly, input logic [63:0] exp_raddr,
                         input logic [63:0] exp_data, input int exp_stall);
    int stalls = 0;
    lq.push_back(exp_data);
    rq.push_back(exp_raddr);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    @(negedge clk); if (mem_stall) stalls++;
    for (int c = 0; c <= dly; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_read = 1'b0;
      if (c == dly) begin rvalid = 1'b1; rdata = rd; end
      else          begin rvalid = 1'b0; rdata = ~rd; end
      @(negedge clk); if (mem_stall) stalls++;
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
    @(negedge clk); if (mem_stall) stalls++;
    check({nm, "_stall"}, 64'(stalls), 64'(exp_stall));
  endtask

  task automatic do_store(input string nm, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int dly, input logic [63:0] exp_waddr,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_mask,
                          input int exp_en, input int exp_stall);
    int stalls = 0;
    int ens = 0;
    wq_addr.push_back(exp_waddr);
    wq_data.push_back(exp_wdata);
    wq_mask.push_back(exp_mask);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk); if (mem_stall) stalls++; if (w_en) ens++;
    for (int c = 0; c <= dly; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_write = 1'b0; wdata = '0;
      wready = (c == dly);
      @(negedge clk); if (mem_stall) stalls++; if (w_en) ens++;
    end
    @(posedge clk); #1;
    wready = 1'b0;
    @(negedge clk); if (mem_stall) stalls++; if (w_en) ens++;
    check({nm, "_stall"}, 64'(stalls), 64'(exp_stall));
    check({nm, "_en_cycles"}, 64'(ens), 64'(exp_en));
  endtask

  task automatic do_fault(input string nm, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [63:0] a);
    fq.push_back(1);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    @(negedge clk);
    check({nm, "_stall"}, 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({nm, "_fault"}, 64'(access_fault), 64'd1);
    check({nm, "_enables"}, 64'({r_en, w_en}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_fault_end"}, 64'(access_fault), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0; rvalid = 1'b0; rdata = '0; wready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(mem_stall), 64'd0);
    check("rst_enables", 64'({r_en, w_en, load_valid, access_fault}), 64'd0);
    check("rst_load_data", load_data, 64'd0);
    check("rst_w_fields", w_addr | w_data | 64'(w_mask) | r_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load("ld",  3'b011, 64'h8000_0010, 64'h1122_3344_5566_7788, 0,
            64'h8000_0010, 64'h1122_3344_5566_7788, 2);
    do_load("lb",  3'b000, 64'h8000_0013, 64'h0000_0000_8000_0000, 1,
            64'h8000_0010, 64'hFFFF_FFFF_FFFF_FF80, 3);
    do_load("lbu", 3'b100, 64'h8000_0013, 64'h0000_0000_8000_0000, 0,
            64'h8000_0010, 64'h0000_0000_0000_0080, 2);
    do_load("lhu", 3'b101, 64'h8000_0012, 64'h0000_0000_8000_0000, 0,
            64'h8000_0010, 64'h0000_0000_0000_8000, 2);
    do_load("lw",  3'b010, 64'h8000_0014, 64'h8765_4321_0000_0000, 0,
            64'h8000_0010, 64'hFFFF_FFFF_8765_4321, 2);
    do_store("sh", 3'b001, 64'h8000_0016, 64'h0000_0000_0000_ABCD, 3,
             64'h8000_0010, 64'hABCD_0000_0000_0000, 8'hC0, 4, 5);

    do_fault("lw_mis",  1'b1, 1'b0, 3'b010, 64'h8000_0002);
    do_fault("sd_mis",  1'b0, 1'b1, 3'b011, 64'h8000_0004);
    do_fault("ld_f111", 1'b1, 1'b0, 3'b111, 64'h8000_0000);
    do_fault("st_f100", 1'b0, 1'b1, 3'b100, 64'h8000_0000);

    // Stray bus responses while idle must not produce any activity.
    @(posedge clk); #1;
    rvalid = 1'b1; wready = 1'b1; rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    @(negedge clk);
    check("late_resp_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; wready = 1'b0;
    @(negedge clk);
    check("late_resp_quiet", 64'({r_en, w_en, load_valid}), 64'd0);
    check("late_resp_hold", load_data, 64'hFFFF_FFFF_8765_4321);

    do_store("sw_b2b", 3'b010, 64'h8000_0020, 64'hDEAD_BEEF_1234_5678, 0,
             64'h8000_0020, 64'hDEAD_BEEF_1234_5678, 8'h0F, 1, 2);
    do_load("ld_b2b", 3'b011, 64'h8000_0028, 64'hCAFE_F00D_0BAD_BEEF, 0,
            64'h8000_0028, 64'hCAFE_F00D_0BAD_BEEF, 2);

    // Reset while a load waits on the bus; the following response is ignored.
    rq.push_back(64'h8000_0040);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b011; addr = 64'h8000_0040;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("rdwait_stall", 64'(mem_stall), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; rdata = 64'h5555_6666_7777_8888;
    @(negedge clk);
    check("rst_mid_ren", 64'(r_en), 64'd0);
    check("rst_mid_stall2", 64'(mem_stall), 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_lvalid", 64'(load_valid), 64'd0);
    check("rst_mid_ldata", load_data, 64'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lq_drained", 64'(lq.size()), 64'd0);
    check("rq_drained", 64'(rq.size()), 64'd0);
    check("wq_drained", 64'(wq_addr.size()), 64'd0);
    check("fq_drained", 64'(fq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
